// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU data port
// and the external loader port.
package mem_arb_pkg;

  localparam int WCNT_W = 8;

  typedef enum logic {
    S_CPU,
    S_FORCE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LD
  } owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of CPU, loader and memory-side signals around mem_arbiter.
// slave = arbiter view; master = surrounding CPU/loader/memory view.
interface mem_arb_if #(
  parameter int DATA_W = 22
);

  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [DATA_W-1:0] ld_adr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;

  logic              mem_we;
  logic [DATA_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_read, cpu_write, cpu_adr, cpu_wdata,
    input  ld_req, ld_we, ld_adr, ld_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_we, mem_adr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_adr, cpu_wdata,
    output ld_req, ld_we, ld_adr, ld_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_we, mem_adr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied loader-request cycles; force_next flags the cycle whose
// increment reaches STARVE_LIM so the arbiter forces a loader grant next cycle.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic force_next
);

  localparam logic [WCNT_W-1:0] LIM = WCNT_W'(STARVE_LIM);

  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_inc;

  assign wcnt_inc   = wcnt + WCNT_W'(1);
  assign force_next = ld_req & ~ld_gnt & (wcnt_inc == LIM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 wcnt <= '0;
    else if (!ld_req || ld_gnt || force_next) wcnt <= '0;
    else                                     wcnt <= wcnt_inc;
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU-priority arbiter for the shared data memory with starvation-forced loader grants.
// Optional MEM_ARB_STATS_EN adds saturating stall_cnt / ld_cnt outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 22,
  parameter int STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arb_if.slave     bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]  stall_cnt,
  output logic [15:0]  ld_cnt
`endif
);

  arb_state_t        state, state_next;
  owner_t            owner, rd_own, rd_own_next;
  logic              cpu_act;
  logic              force_gnt;
  logic              force_next;
  logic [DATA_W-1:0] adr_mux, wdata_mux;

  assign cpu_act = bus.cpu_read | bus.cpu_write;

  mem_arb_starve_cnt #(.STARVE_LIM(STARVE_LIM)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .ld_req    (bus.ld_req),
    .ld_gnt    (bus.ld_gnt),
    .force_next(force_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_CPU;
      rd_own <= OWN_CPU;
    end else begin
      state  <= state_next;
      rd_own <= rd_own_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    owner       = OWN_NONE;
    force_gnt   = 1'b0;
    state_next  = force_next ? S_FORCE : S_CPU;
    rd_own_next = OWN_NONE;
    if (rst) begin
      owner = OWN_NONE;
    end else if (state == S_FORCE && bus.ld_req) begin
      owner     = OWN_LD;
      force_gnt = 1'b1;
    end else if (cpu_act) begin
      owner = OWN_CPU;
    end else if (bus.ld_req) begin
      owner = OWN_LD;
    end
    if (owner == OWN_LD && !bus.ld_we)        rd_own_next = OWN_LD;
    else if (owner == OWN_CPU && bus.cpu_read) rd_own_next = OWN_CPU;
  end

  // With no owner the address bus keeps the CPU address; reset clamps it to zero.
  always_comb begin
    adr_mux   = (owner == OWN_LD) ? bus.ld_adr   : bus.cpu_adr;
    wdata_mux = (owner == OWN_LD) ? bus.ld_wdata : bus.cpu_wdata;
    unique case (owner)
      OWN_CPU: bus.mem_we = bus.cpu_write;
      OWN_LD:  bus.mem_we = bus.ld_we;
      default: bus.mem_we = 1'b0;
    endcase
  end

  assign bus.mem_adr   = rst ? {DATA_W{1'b0}} : adr_mux;
  assign bus.mem_wdata = rst ? {DATA_W{1'b0}} : wdata_mux;
  assign bus.ld_gnt    = (owner == OWN_LD);
  assign bus.cpu_stall = force_gnt & cpu_act;
  assign bus.ld_rvalid = (rd_own == OWN_LD);
  assign bus.ld_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata = bus.mem_rdata;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      ld_cnt    <= '0;
    end else begin
      if (bus.cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (bus.ld_gnt && ld_cnt != 16'hFFFF)       ld_cnt    <= ld_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level model of the arbitration rules and a golden memory.
module tb_mem_arbiter;

  localparam int DW  = 22;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if #(.DATA_W(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cnt, ld_cnt;
`endif

  mem_arbiter #(.DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .ld_cnt(ld_cnt)
`endif
  );

  // NOTE: memory arrays are initialised, never reset; only control state sees rst.
  logic [DW-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_adr[3:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_adr[3:0]];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: denial streak, pending force, pending read returns, golden memory.
  int            m_denied = 0;
  bit            m_force  = 0;
  bit            m_ld_rd  = 0;
  bit            m_cpu_rd = 0;
  logic [DW-1:0] m_rd_val = '0;
  logic [DW-1:0] golden [16] = '{default: '0};

  bit            e_gnt, e_stall, e_we, e_rvalid, e_cpu_chk;
  logic [DW-1:0] e_adr, e_wdata, e_rdata;

  task automatic model_reset();
    m_denied = 0;
    m_force  = 0;
    m_ld_rd  = 0;
    m_cpu_rd = 0;
  endtask

  task automatic set_idle();
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_adr = '0; bus.ld_wdata = '0;
  endtask

  // Apply one cycle of inputs, then compute what the spec says must be visible now.
  task automatic drive(input bit cr, input bit cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                       input bit lr, input bit lw, input logic [DW-1:0] la, input logic [DW-1:0] ld);
    bit own_ld, own_cpu;
    @(negedge clk);
    bus.cpu_read = cr; bus.cpu_write = cw; bus.cpu_adr = ca; bus.cpu_wdata = cd;
    bus.ld_req = lr; bus.ld_we = lw; bus.ld_adr = la; bus.ld_wdata = ld;
    #1;
    e_rvalid  = m_ld_rd;
    e_cpu_chk = m_cpu_rd;
    e_rdata   = m_rd_val;
    own_ld    = lr && (m_force || !(cr || cw));
    own_cpu   = !own_ld && (cr || cw);
    e_gnt     = own_ld;
    e_stall   = m_force && lr && (cr || cw);
    e_we      = own_ld ? lw : (own_cpu ? cw : 1'b0);
    e_adr     = own_ld ? la : ca;
    e_wdata   = own_ld ? ld : cd;
    m_ld_rd   = own_ld && !lw;
    m_cpu_rd  = own_cpu && cr;
    m_rd_val  = golden[e_adr[3:0]];
    if (e_we) golden[e_adr[3:0]] = e_wdata;
    if (lr && !own_ld) begin
      m_denied++;
      m_force = (m_denied == LIM);
      if (m_force) m_denied = 0;
    end else begin
      m_denied = 0;
      m_force  = 0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    bus.ld_req  = 1;
    bus.cpu_adr = DW'(21);
    #2;
    n_vec++; if (bus.ld_gnt !== 1'b0) begin n_err++; $display("FAIL reset.gnt got=%0b want=0", bus.ld_gnt); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset.we got=%0b want=0", bus.mem_we); end
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset.stall got=%0b want=0", bus.cpu_stall); end
    n_vec++; if (bus.ld_rvalid !== 1'b0) begin n_err++; $display("FAIL reset.rvalid got=%0b want=0", bus.ld_rvalid); end
    n_vec++; if (bus.mem_adr !== '0) begin n_err++; $display("FAIL reset.adr got=%0h want=0", bus.mem_adr); end
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_cpu_only();
    drive(0, 1, DW'(5), DW'('h2A), 0, 0, '0, '0);
    n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL cpu_only.we got=%0b want=1", bus.mem_we); end
    n_vec++; if (bus.mem_adr !== DW'(5)) begin n_err++; $display("FAIL cpu_only.adr got=%0h want=5", bus.mem_adr); end
    n_vec++; if (bus.mem_wdata !== DW'('h2A)) begin n_err++; $display("FAIL cpu_only.wdata got=%0h want=2a", bus.mem_wdata); end
    drive(1, 0, DW'(5), '0, 0, 0, '0, '0);
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL cpu_only.rd_we got=%0b want=0", bus.mem_we); end
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_only.stall got=%0b want=0", bus.cpu_stall); end
    drive(0, 0, DW'(5), '0, 0, 0, '0, '0);
    n_vec++; if (bus.cpu_rdata !== DW'('h2A)) begin n_err++; $display("FAIL cpu_only.rdata got=%0h want=2a", bus.cpu_rdata); end
  endtask

  task automatic test_loader_idle();
    drive(0, 0, '0, '0, 1, 0, DW'(5), '0);
    n_vec++; if (bus.ld_gnt !== 1'b1) begin n_err++; $display("FAIL ld_idle.gnt got=%0b want=1", bus.ld_gnt); end
    n_vec++; if (bus.mem_adr !== DW'(5)) begin n_err++; $display("FAIL ld_idle.adr got=%0h want=5", bus.mem_adr); end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++; if (bus.ld_rvalid !== 1'b1) begin n_err++; $display("FAIL ld_idle.rvalid got=%0b want=1", bus.ld_rvalid); end
    n_vec++; if (bus.ld_rdata !== DW'('h2A)) begin n_err++; $display("FAIL ld_idle.rdata got=%0h want=2a", bus.ld_rdata); end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++; if (bus.ld_rvalid !== 1'b0) begin n_err++; $display("FAIL ld_idle.rvalid_drop got=%0b want=0", bus.ld_rvalid); end
  endtask

  task automatic test_starvation();
    for (int c = 1; c <= LIM; c++) begin
      drive(1, 0, DW'(3), '0, 1, 1, DW'(7), DW'('h11));
      n_vec++; if (bus.ld_gnt !== 1'b0) begin n_err++; $display("FAIL starve.gnt c%0d got=%0b want=0", c, bus.ld_gnt); end
    end
    drive(1, 0, DW'(3), '0, 1, 1, DW'(7), DW'('h11));
    n_vec++; if (bus.ld_gnt !== 1'b1) begin n_err++; $display("FAIL starve.force_gnt got=%0b want=1", bus.ld_gnt); end
    n_vec++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL starve.stall got=%0b want=1", bus.cpu_stall); end
    n_vec++; if (bus.mem_adr !== DW'(7)) begin n_err++; $display("FAIL starve.adr got=%0h want=7", bus.mem_adr); end
    n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL starve.we got=%0b want=1", bus.mem_we); end
    n_vec++; if (bus.mem_wdata !== DW'('h11)) begin n_err++; $display("FAIL starve.wdata got=%0h want=11", bus.mem_wdata); end
    drive(1, 0, DW'(3), '0, 0, 0, '0, '0);
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve.after_stall got=%0b want=0", bus.cpu_stall); end
    n_vec++; if (bus.mem_adr !== DW'(3)) begin n_err++; $display("FAIL starve.after_adr got=%0h want=3", bus.mem_adr); end
  endtask

  task automatic test_req_drop();
    for (int c = 1; c <= LIM; c++) drive(1, 0, DW'(3), '0, 1, 1, DW'(12), DW'('h55));
    drive(1, 0, DW'(3), '0, 0, 0, '0, '0);
    n_vec++; if (bus.ld_gnt !== 1'b0) begin n_err++; $display("FAIL drop.gnt got=%0b want=0", bus.ld_gnt); end
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL drop.stall got=%0b want=0", bus.cpu_stall); end
    n_vec++; if (bus.mem_adr !== DW'(3)) begin n_err++; $display("FAIL drop.adr got=%0h want=3", bus.mem_adr); end
    for (int c = 1; c <= LIM; c++) begin
      drive(1, 0, DW'(3), '0, 1, 1, DW'(12), DW'('h55));
      n_vec++; if (bus.ld_gnt !== 1'b0) begin n_err++; $display("FAIL drop.regrant c%0d got=%0b want=0", c, bus.ld_gnt); end
    end
    drive(1, 0, DW'(3), '0, 1, 1, DW'(12), DW'('h55));
    n_vec++; if (bus.ld_gnt !== 1'b1) begin n_err++; $display("FAIL drop.force_gnt got=%0b want=1", bus.ld_gnt); end
    drive(1, 0, DW'(3), '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset_force();
    logic [DW-1:0] saved;
    saved = golden[9];
    for (int c = 1; c <= LIM; c++) drive(1, 0, DW'(3), '0, 1, 1, DW'(9), DW'('h33));
    drive(1, 0, DW'(3), '0, 1, 1, DW'(9), DW'('h33));
    n_vec++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL rst_force.pre_stall got=%0b want=1", bus.cpu_stall); end
    rst = 1;
    #1;
    n_vec++; if (bus.ld_gnt !== 1'b0) begin n_err++; $display("FAIL rst_force.gnt got=%0b want=0", bus.ld_gnt); end
    n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_force.stall got=%0b want=0", bus.cpu_stall); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_force.we got=%0b want=0", bus.mem_we); end
    n_vec++; if (bus.mem_wdata !== '0) begin n_err++; $display("FAIL rst_force.wdata got=%0h want=0", bus.mem_wdata); end
    golden[9] = saved;
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    drive(0, 0, '0, '0, 1, 0, DW'(5), '0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++; if (bus.ld_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_force.rvalid_pre got=%0b want=1", bus.ld_rvalid); end
    rst = 1;
    #1;
    n_vec++; if (bus.ld_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_force.rvalid_drop got=%0b want=0", bus.ld_rvalid); end
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit            lact = 0, lw = 0, cr, cw;
    logic [DW-1:0] la = '0, ld = '0;
    int            op;
    for (int i = 0; i < 600; i++) begin
      if (!lact && $urandom_range(2) == 0) begin
        lact = 1;
        lw   = 1'($urandom_range(1));
        la   = DW'($urandom_range(15));
        ld   = DW'($urandom);
      end
      op = int'($urandom_range(3));
      cr = (op == 1 || op == 2);
      cw = (op == 3);
      drive(cr, cw, DW'($urandom_range(15)), DW'($urandom), lact, lw, la, ld);
      n_vec++; if (bus.ld_gnt !== e_gnt) begin n_err++; $display("FAIL rnd.gnt i%0d got=%0b want=%0b", i, bus.ld_gnt, e_gnt); end
      n_vec++; if (bus.cpu_stall !== e_stall) begin n_err++; $display("FAIL rnd.stall i%0d got=%0b want=%0b", i, bus.cpu_stall, e_stall); end
      n_vec++; if (bus.mem_we !== e_we) begin n_err++; $display("FAIL rnd.we i%0d got=%0b want=%0b", i, bus.mem_we, e_we); end
      n_vec++; if (bus.mem_adr !== e_adr) begin n_err++; $display("FAIL rnd.adr i%0d got=%0h want=%0h", i, bus.mem_adr, e_adr); end
      if (e_we) begin
        n_vec++; if (bus.mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd.wdata i%0d got=%0h want=%0h", i, bus.mem_wdata, e_wdata); end
      end
      n_vec++; if (bus.ld_rvalid !== e_rvalid) begin n_err++; $display("FAIL rnd.rvalid i%0d got=%0b want=%0b", i, bus.ld_rvalid, e_rvalid); end
      if (e_rvalid) begin
        n_vec++; if (bus.ld_rdata !== e_rdata) begin n_err++; $display("FAIL rnd.ld_rdata i%0d got=%0h want=%0h", i, bus.ld_rdata, e_rdata); end
      end
      if (e_cpu_chk) begin
        n_vec++; if (bus.cpu_rdata !== e_rdata) begin n_err++; $display("FAIL rnd.cpu_rdata i%0d got=%0h want=%0h", i, bus.cpu_rdata, e_rdata); end
      end
      if (e_gnt) lact = 0;
    end
    set_idle();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1;
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c <= LIM; c++) drive(1, 0, DW'(2), '0, 1, 1, DW'(10 + r), DW'(r + 1));
      drive(1, 0, DW'(2), '0, 0, 0, '0, '0);
    end
    n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL stats.stall_cnt got=%0d want=3", stall_cnt); end
    n_vec++; if (ld_cnt !== 16'd3) begin n_err++; $display("FAIL stats.ld_cnt got=%0d want=3", ld_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_only();
    test_loader_idle();
    test_starvation();
    test_req_drop();
    test_reset_force();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single data memory between the pipelined processor's data port and an external loader port (host/DMA that fills or drains data memory). The CPU has priority. The loader is served on CPU-idle cycles. A starvation counter forces a one-cycle loader grant and stalls the CPU when the loader has waited too long. It sits between the processor's `mem_read`/`mem_write`/`data_adr`/`write_data`/`read_data` pins and the data memory.

## Interface
Parameters:
- `DATA_W`, 22, data and address width (matches processor word)
- `STARVE_LIM`, 4, consecutive denied loader-request cycles before a forced grant (range 1..255)

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `cpu_read`  in  1  CPU load request (processor `mem_read`)
- `cpu_write`  in  1  CPU store request (processor `mem_write`)
- `cpu_adr`  in  DATA_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_rdata`  out  DATA_W  load data to processor `read_data`
- `cpu_stall`  out  1  CPU access not performed this cycle; pipeline must hold
- `ld_req`  in  1  loader access request, held until granted
- `ld_we`  in  1  loader write (1) / read (0)
- `ld_adr`  in  DATA_W  loader address
- `ld_wdata`  in  DATA_W  loader write data
- `ld_gnt`  out  1  loader access performed this cycle
- `ld_rdata`  out  DATA_W  loader read data
- `ld_rvalid`  out  1  `ld_rdata` valid (1 cycle after a granted read)
- `mem_we`  out  1  memory write enable
- `mem_adr`  out  DATA_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, 1-cycle synchronous read

## Operation
- `cpu_act = cpu_read | cpu_write`.
- States: `S_CPU` (normal) and `S_FORCE` (loader forced). Reset enters `S_CPU`.
- `S_CPU`:
  - If `cpu_act` is high, the CPU owns memory and `ld_gnt=0`.
  - Else, if `ld_req` is high, the loader owns memory and `ld_gnt=1`.
  - Else, memory is idle and `mem_we=0`.
- `S_FORCE`:
  - If `ld_req` is high, the loader owns memory, `ld_gnt=1`, and `cpu_stall=cpu_act`.
  - If `ld_req` is low, behave as `S_CPU` with no stall.
  - Always return to `S_CPU` next cycle.
- Wait counter `wcnt` (8 bit):
  - Cleared when `ld_gnt=1` or `ld_req=0`.
  - Increments on each cycle with `ld_req=1`, `ld_gnt=0`.
  - When the increment makes `wcnt==STARVE_LIM`, the next state is `S_FORCE` and `wcnt` clears.
- Owner mux: `mem_adr`/`mem_wdata` come from the owner. `mem_we = cpu_write` or `ld_we`, gated by ownership. With no owner, `mem_adr` holds the CPU address.
- `cpu_stall` is asserted only in `S_FORCE` with a loader grant. Otherwise it is 0.
- Read return:
  - Registered owner tag `rd_own` records who issued a read.
  - `ld_rvalid` is registered: 1 in the cycle after a granted loader read (`ld_gnt & ~ld_we`).
  - `ld_rdata = mem_rdata`, `cpu_rdata = mem_rdata`. `cpu_rdata` is meaningful only when `rd_own` = CPU.
- Simultaneous `cpu_act` and `ld_req` in `S_CPU` below the limit: CPU wins and the loader waits (counter increments).

## Timing
- Grant, `mem_*`, and `cpu_stall` are combinational from the inputs and the registered state; zero added latency.
- Read data arrives 1 cycle after the granted address cycle.
- Worst-case loader wait is `STARVE_LIM` cycles; granted on cycle `STARVE_LIM+1` of continuous request.
- CPU stalls at most 1 cycle per `STARVE_LIM+1` cycles.
- Reset (async, any time, including mid-`S_FORCE`) immediately forces:
  - state `S_CPU`, `wcnt=0`, `rd_own`=CPU
  - `ld_rvalid=0`, `ld_gnt=0`, `cpu_stall=0`, `mem_we=0`
  - `mem_adr=0`, `mem_wdata=0` while `rst` is high
- A pending `ld_rvalid` is dropped by reset.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds output `stall_cnt` [15:0]: CPU stall cycles, saturating at 16'hFFFF.
  - Adds output `ld_cnt` [15:0]: loader grants, saturating.
  - Both are 0 at reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t {S_CPU, S_FORCE}`
  - owner enum `owner_t {OWN_NONE, OWN_CPU, OWN_LD}`
  - constant `WCNT_W=8`
- One sub-module: `mem_arb_starve_cnt` (wait counter plus limit compare, outputs `force_next`).

## Test plan
- Reset: assert `rst` mid-`S_FORCE` -> `ld_gnt=0`, `cpu_stall=0`, `mem_we=0`, `ld_rvalid=0` immediately.
- CPU only: store `adr=5`, `data=0x2A`, then load `adr=5` -> `mem_we=1` on cycle 1; `cpu_rdata=0x2A` one cycle after the load; `cpu_stall` never 1.
- Loader on idle CPU: `ld_req`, `ld_we=0`, `adr=5` -> `ld_gnt=1` same cycle; `ld_rvalid=1`, `ld_rdata=0x2A` next cycle.
- Starvation: `cpu_read` held high, `ld_req` held high (loader write `adr=7`, `data=0x11`), `STARVE_LIM=4` -> `ld_gnt=0` for 4 cycles. Cycle 5: `ld_gnt=1`, `cpu_stall=1`, `mem_adr=7`, `mem_we=1`. Cycle 6: CPU owns again.
- Request drop: `ld_req` falls in the cycle `S_FORCE` is entered -> no stall, `ld_gnt=0`, `wcnt=0`.
- `MEM_ARB_STATS_EN`: repeat starvation for 3 forced grants -> `stall_cnt=3`, `ld_cnt=3`.
